aes_inv_key_schedule: RTL and testbench

Backward (decryption-order) AES-128 key schedule. It accepts the round-10 key and regenerates round keys 10, 9, … 0 on the fly, one per handshake, recovering the original cipher key at the end. It sits between the key-expansion stage and the inverse-cipher datapath, so decryption can run without an 11-entry round-key memory.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_inv_key_step.sv | 38 +++
 rtl/aes_inv_key_schedule.sv | 113 +++++++++++
 tb/tb_aes_inv_key_schedule.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the forward key schedule, the inverse key
// schedule and the cipher datapath.
//   NR, KEY_W   : AES-128 round count and key width
//   ks_state_t  : key-schedule controller states (IDLE / EMIT / DONE)
//   sbox()      : forward AES S-box lookup
//   rcon()      : round constant byte for rounds 1..10 (0 elsewhere)
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int NR    = 10;
   localparam int KEY_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } ks_state_t;

   // Row-major S-box table, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry x sits at bit 8*(255-x)+7, which is simply {~x, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// ---------------------------------------------------------------------------
// aes_inv_key_step
// Combinational inverse AES-128 key-expansion step: derives the round r-1
// key from the round r key.
//   key_i      [127:0] round r key, w0 = key_i[127:96] .. w3 = key_i[31:0]
//   round_i    [3:0]   r, selects Rcon[r]
//   key_prev_o [127:0] round r-1 key
// ---------------------------------------------------------------------------
module aes_inv_key_step (
   input  logic [127:0] key_i,
   input  logic [3:0]   round_i,
   output logic [127:0] key_prev_o
);
   import aes_pkg::*;

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] w0_prev, w1_prev, w2_prev, w3_prev;
   logic [31:0] rot_w, sub_w;

   assign {w0, w1, w2, w3} = key_i;

   // Words 1..3 are undone from the top down; each needs only its
   // (still forward-order) left neighbour.
   assign w3_prev = w3 ^ w2;
   assign w2_prev = w2 ^ w1;
   assign w1_prev = w1 ^ w0;

   // w0 needs the recovered w3 of the previous round, not the current one.
   assign rot_w = {w3_prev[23:0], w3_prev[31:24]};

   assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                   sbox(rot_w[15:8]),  sbox(rot_w[7:0])};

   assign w0_prev = w0 ^ sub_w ^ {rcon(round_i), 24'h0};

   assign key_prev_o = {w0_prev, w1_prev, w2_prev, w3_prev};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_inv_key_schedule
// Backward AES-128 key schedule: takes the round-10 key and hands out round
// keys 10 down to 0 over a valid/ready interface, then presents the
// recovered cipher key.
//   clk_i       clock, rising edge
//   reset_n_i   asynchronous active-low reset
//   start_i     begin a schedule (honoured in IDLE or DONE only)
//   last_key_i  round-10 key, captured with start_i
//   rk_o        current round key
//   rk_round_o  round index of rk_o (10..0)
//   rk_valid_o  rk_o / rk_round_o valid
//   rk_ready_i  consumer ready
//   busy_o      schedule in progress
//   done_o      one-cycle pulse after round key 0 is accepted
//   key_o       recovered cipher key, held until the next start
// ---------------------------------------------------------------------------
module aes_inv_key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         start_i,
   input  logic [127:0] last_key_i,
   output logic [127:0] rk_o,
   output logic [3:0]   rk_round_o,
   output logic         rk_valid_o,
   input  logic         rk_ready_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [127:0] key_o
);
   import aes_pkg::*;

   localparam int RND_W = $clog2(NR + 1);

   ks_state_t          state_q, state_d;
   logic [KEY_W-1:0]   rk_q;
   logic [KEY_W-1:0]   key_q;
   logic [KEY_W-1:0]   key_prev;
   logic [RND_W-1:0]   round_q;
   logic               done_q;
   logic               load;
   logic               step;
   logic               finish;
   logic               handshake;

   aes_inv_key_step u_step (
      .key_i      (rk_q),
      .round_i    (4'(round_q)),
      .key_prev_o (key_prev)
   );

   assign handshake = (state_q == EMIT) && rk_ready_i;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               load    = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (handshake) begin
               if (round_q == '0) begin
                  finish  = 1'b1;
                  state_d = DONE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         rk_q    <= '0;
         round_q <= '0;
         key_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // done_o is high only on the first DONE cycle.
         done_q  <= finish;
         if (load) begin
            rk_q    <= last_key_i;
            round_q <= RND_W'(NR);
         end else if (step) begin
            rk_q    <= key_prev;
            round_q <= round_q - RND_W'(1);
         end
         if (finish) begin
            key_q <= rk_q;
         end
      end
   end

   assign rk_o       = rk_q;
   assign rk_round_o = 4'(round_q);
   assign rk_valid_o = (state_q == EMIT);
   assign busy_o     = (state_q == EMIT);
   assign done_o     = done_q;
   assign key_o      = key_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_schedule
// Directed bench for aes_inv_key_schedule using the FIPS-197 A.1 key
// (2b7e1516...) and the all-zero key.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_schedule;

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic         start_i;
   logic [127:0] last_key_i;
   logic [127:0] rk_o;
   logic [3:0]   rk_round_o;
   logic         rk_valid_o;
   logic         rk_ready_i;
   logic         busy_o;
   logic         done_o;
   logic [127:0] key_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [127:0] kexp [0:10];
   localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_inv_key_schedule dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .start_i    (start_i),
      .last_key_i (last_key_i),
      .rk_o       (rk_o),
      .rk_round_o (rk_round_o),
      .rk_valid_o (rk_valid_o),
      .rk_ready_i (rk_ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .key_o      (key_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_start(input logic [127:0] k);
      last_key_i = k;
      start_i    = 1'b1;
      tick();
      start_i    = 1'b0;
   endtask

   // Walk rounds from_r..to_r with ready high; optionally pulse start_i
   // with a different key while round inject_r is on the bus.
   task automatic walk(input int from_r, input int to_r, input int inject_r);
      rk_ready_i = 1'b1;
      for (int r = from_r; r >= to_r; r--) begin
         chk($sformatf("valid_r%0d", r), {127'd0, rk_valid_o}, 128'd1);
         chk($sformatf("round_r%0d", r), {124'd0, rk_round_o}, 128'(r));
         chk($sformatf("key_r%0d", r), rk_o, kexp[r]);
         chk($sformatf("nodone_r%0d", r), {127'd0, done_o}, 128'd0);
         if (r == inject_r) begin
            last_key_i = ZERO_K10;
            start_i    = 1'b1;
         end else begin
            start_i    = 1'b0;
         end
         tick();
      end
      start_i = 1'b0;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_done"},  {127'd0, done_o},     128'd1);
      chk({tag, "_busy"},  {127'd0, busy_o},     128'd0);
      chk({tag, "_valid"}, {127'd0, rk_valid_o}, 128'd0);
      chk({tag, "_keyo"},  key_o,                kexp[0]);
   endtask

   initial begin
      int  r;
      int  cyc;
      logic rdy;
      logic seen;

      kexp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      kexp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      kexp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      kexp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      kexp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      kexp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      kexp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      kexp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      kexp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      kexp[9]  = 128'hac7766f319fadc2128d12941575c006e;
      kexp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset_n_i  = 1'b0;
      start_i    = 1'b0;
      last_key_i = '0;
      rk_ready_i = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_rk",    rk_o,                     128'd0);
      chk("rst_round", {124'd0, rk_round_o},     128'd0);
      chk("rst_valid", {127'd0, rk_valid_o},     128'd0);
      chk("rst_busy",  {127'd0, busy_o},         128'd0);
      chk("rst_done",  {127'd0, done_o},         128'd0);
      chk("rst_keyo",  key_o,                    128'd0);

      // Idle for 20 cycles without start
      reset_n_i  = 1'b1;
      rk_ready_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rk_valid_o || busy_o || done_o) seen = 1'b1;
      end
      chk("idle_quiet", {127'd0, seen}, 128'd0);

      // Full schedule, no backpressure
      do_start(kexp[10]);
      chk("full_busy", {127'd0, busy_o}, 128'd1);
      walk(10, 0, -1);
      chk_done("full");
      chk("full_round0_hold", {124'd0, rk_round_o}, 128'd0);
      tick();
      chk("full_done_pulse", {127'd0, done_o}, 128'd0);
      chk("full_keyo_hold",  key_o,            kexp[0]);

      // Random backpressure
      do_start(kexp[10]);
      r = 10;
      cyc = 0;
      while (r >= 0 && cyc < 400) begin
         chk($sformatf("bp_valid_r%0d", r), {127'd0, rk_valid_o}, 128'd1);
         chk($sformatf("bp_round_r%0d", r), {124'd0, rk_round_o}, 128'(r));
         chk($sformatf("bp_key_r%0d", r),   rk_o,                 kexp[r]);
         rdy = 1'($urandom_range(0, 1));
         rk_ready_i = rdy;
         tick();
         cyc++;
         if (rdy) r--;
      end
      chk("bp_budget", 128'(r), 128'(-1));
      chk_done("bp");
      rk_ready_i = 1'b1;
      tick();

      // start_i with a different key during round 5 is ignored
      do_start(kexp[10]);
      walk(10, 0, 5);
      chk_done("ign");
      tick();

      // Reset at round 4 aborts asynchronously
      do_start(kexp[10]);
      walk(10, 5, -1);
      chk("mid_round4", {124'd0, rk_round_o}, 128'd4);
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("arst_rk",    rk_o,                 128'd0);
      chk("arst_round", {124'd0, rk_round_o}, 128'd0);
      chk("arst_valid", {127'd0, rk_valid_o}, 128'd0);
      chk("arst_busy",  {127'd0, busy_o},     128'd0);
      chk("arst_done",  {127'd0, done_o},     128'd0);
      chk("arst_keyo",  key_o,                128'd0);
      tick();
      reset_n_i = 1'b1;
      tick();
      do_start(kexp[10]);
      walk(10, 0, -1);
      chk_done("after_rst");

      // Back-to-back: restart in the done_o cycle with the all-zero key
      do_start(ZERO_K10);
      chk("b2b_done_low", {127'd0, done_o},     128'd0);
      chk("b2b_valid",    {127'd0, rk_valid_o}, 128'd1);
      chk("b2b_round10",  {124'd0, rk_round_o}, 128'd10);
      chk("b2b_key10",    rk_o,                 ZERO_K10);
      rk_ready_i = 1'b1;
      for (int i = 10; i >= 0; i--) begin
         chk($sformatf("b2b_round_r%0d", i), {124'd0, rk_round_o}, 128'(i));
         tick();
      end
      chk("b2b_done",  {127'd0, done_o}, 128'd1);
      chk("b2b_keyo",  key_o,            128'd0);
      chk("b2b_rk0",   rk_o,             128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
